// File: rtl/alu_exec.sv
// alu_exec: single-issue RV32I integer execute stage with a one-cycle registered result broadcast.
// Optional macro ALU_STATS_EN adds the stat_ops / stat_taken accepted-op and taken-jump counters.

`ifndef OPCODE_WID
`define OPCODE_WID 6:0
`endif
`ifndef FUNCT3_WID
`define FUNCT3_WID 2:0
`endif
`ifndef DATA_WID
`define DATA_WID 31:0
`endif
`ifndef ADDR_WID
`define ADDR_WID 31:0
`endif
`ifndef ROB_POS_WID
`define ROB_POS_WID 3:0
`endif

module alu_exec (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback,
    input  logic                alu_en,
    input  logic [`OPCODE_WID]  alu_opcode,
    input  logic [`FUNCT3_WID]  alu_funct3,
    input  logic                alu_funct7,
    input  logic [`DATA_WID]    alu_val1,
    input  logic [`DATA_WID]    alu_val2,
    input  logic [`DATA_WID]    alu_imm,
    input  logic [`ADDR_WID]    alu_pc,
    input  logic [`ROB_POS_WID] alu_rob_pos,
    output logic                result,
    output logic [`ROB_POS_WID] result_rob_pos,
    output logic [`DATA_WID]    result_val,
    output logic                result_jump,
    output logic [`ADDR_WID]    result_pc
`ifdef ALU_STATS_EN
    ,
    output logic [31:0]         stat_ops,
    output logic [31:0]         stat_taken
`endif
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    function automatic logic [31:0] arith(
        input logic [2:0]  f3,
        input logic        do_sub,
        input logic        do_sra,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [4:0]  sh;
        logic [31:0] r;
        sh = b[4:0];
        case (f3)
            3'b000:  r = do_sub ? (a - b) : (a + b);
            3'b001:  r = a << sh;
            3'b010:  r = {31'd0, ($signed(a) < $signed(b))};
            3'b011:  r = {31'd0, (a < b)};
            3'b100:  r = a ^ b;
            3'b101:  r = do_sra ? $unsigned($signed(a) >>> sh) : (a >> sh);
            3'b110:  r = a | b;
            3'b111:  r = a & b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // funct3 010/011 are not defined branch conditions and never take.
    function automatic logic branch_taken(
        input logic [2:0]  f3,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic t;
        case (f3)
            3'b000:  t = (a == b);
            3'b001:  t = (a != b);
            3'b100:  t = ($signed(a) <  $signed(b));
            3'b101:  t = ($signed(a) >= $signed(b));
            3'b110:  t = (a <  b);
            3'b111:  t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    logic [31:0] operand2_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] pc_imm_s;
    logic [31:0] jalr_sum_s;
    logic [31:0] exec_val_s;
    logic        exec_jump_s;
    logic [31:0] exec_pc_s;
    logic        accept_s;

    logic        result_q,  result_d;
    logic [3:0]  rob_pos_q, rob_pos_d;
    logic [31:0] val_q,     val_d;
    logic        jump_q,    jump_d;
    logic [31:0] pc_q,      pc_d;

    assign operand2_s = (alu_opcode == OPC_OP) ? alu_val2 : alu_imm;
    assign pc_plus4_s = alu_pc + 32'd4;
    assign pc_imm_s   = alu_pc + alu_imm;
    assign jalr_sum_s = alu_val1 + alu_imm;
    assign accept_s   = rdy & ~rollback & alu_en;

    // Combinational execute: rd value, control-transfer flag and next PC for the presented op.
    always_comb begin
        exec_val_s  = 32'd0;
        exec_jump_s = 1'b0;
        exec_pc_s   = pc_plus4_s;
        case (alu_opcode)
            OPC_OP: begin
                exec_val_s = arith(alu_funct3, alu_funct7, alu_funct7, alu_val1, operand2_s);
            end
            OPC_OP_IMM: begin
                exec_val_s = arith(alu_funct3, 1'b0, alu_funct7, alu_val1, operand2_s);
            end
            OPC_LUI: begin
                exec_val_s = alu_imm;
            end
            OPC_AUIPC: begin
                exec_val_s = pc_imm_s;
            end
            OPC_JAL: begin
                exec_val_s  = pc_plus4_s;
                exec_jump_s = 1'b1;
                exec_pc_s   = pc_imm_s;
            end
            OPC_JALR: begin
                exec_val_s  = pc_plus4_s;
                exec_jump_s = 1'b1;
                exec_pc_s   = jalr_sum_s & 32'hFFFF_FFFE;
            end
            OPC_BRANCH: begin
                if (branch_taken(alu_funct3, alu_val1, alu_val2)) begin
                    exec_jump_s = 1'b1;
                    exec_pc_s   = pc_imm_s;
                end else begin
                    exec_jump_s = 1'b0;
                    exec_pc_s   = pc_plus4_s;
                end
            end
            default: begin
                exec_val_s = 32'd0;
            end
        endcase
    end

    // Next-state: rollback clears the valid flag, !rdy freezes, otherwise capture on alu_en.
    always_comb begin
        result_d  = result_q;
        rob_pos_d = rob_pos_q;
        val_d     = val_q;
        jump_d    = jump_q;
        pc_d      = pc_q;
        if (rollback) begin
            result_d = 1'b0;
        end else if (rdy) begin
            result_d = alu_en;
            if (alu_en) begin
                rob_pos_d = alu_rob_pos;
                val_d     = exec_val_s;
                jump_d    = exec_jump_s;
                pc_d      = exec_pc_s;
            end else begin
                rob_pos_d = rob_pos_q;
            end
        end else begin
            result_d = result_q;
        end
    end

    // Broadcast registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q  <= 1'b0;
            rob_pos_q <= 4'd0;
            val_q     <= 32'd0;
            jump_q    <= 1'b0;
            pc_q      <= 32'd0;
        end else begin
            result_q  <= result_d;
            rob_pos_q <= rob_pos_d;
            val_q     <= val_d;
            jump_q    <= jump_d;
            pc_q      <= pc_d;
        end
    end

    assign result         = result_q;
    assign result_rob_pos = rob_pos_q;
    assign result_val     = val_q;
    assign result_jump    = jump_q;
    assign result_pc      = pc_q;

`ifdef ALU_STATS_EN
    logic [31:0] stat_ops_q,   stat_ops_d;
    logic [31:0] stat_taken_q, stat_taken_d;

    // Counter next-state: only ops that actually get broadcast are counted.
    always_comb begin
        stat_ops_d   = stat_ops_q;
        stat_taken_d = stat_taken_q;
        if (accept_s) begin
            stat_ops_d = stat_ops_q + 32'd1;
            if (exec_jump_s) begin
                stat_taken_d = stat_taken_q + 32'd1;
            end else begin
                stat_taken_d = stat_taken_q;
            end
        end else begin
            stat_ops_d = stat_ops_q;
        end
    end

    // Statistics registers; cleared by rst only so they survive rollback.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops_q   <= 32'd0;
            stat_taken_q <= 32'd0;
        end else begin
            stat_ops_q   <= stat_ops_d;
            stat_taken_q <= stat_taken_d;
        end
    end

    assign stat_ops   = stat_ops_q;
    assign stat_taken = stat_taken_q;
`else
    logic unused_accept_s;
    assign unused_accept_s = accept_s;
`endif

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed test-plan steps followed by randomized ops,
// all checked against an arithmetic reference model of the execute stage.

module tb_alu_exec;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback, alu_en;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic        alu_funct7;
    logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
    logic [3:0]  alu_rob_pos;
    logic        result;
    logic [3:0]  result_rob_pos;
    logic [31:0] result_val;
    logic        result_jump;
    logic [31:0] result_pc;
`ifdef ALU_STATS_EN
    logic [31:0] stat_ops, stat_taken;
`endif

    int checks = 0;
    int errors = 0;

    logic        m_result;
    logic [3:0]  m_rob;
    logic [31:0] m_val;
    logic        m_jump;
    logic [31:0] m_pc;
    logic [31:0] m_ops;
    logic [31:0] m_taken;

    always #5 clk = ~clk;

    alu_exec dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .rollback       (rollback),
        .alu_en         (alu_en),
        .alu_opcode     (alu_opcode),
        .alu_funct3     (alu_funct3),
        .alu_funct7     (alu_funct7),
        .alu_val1       (alu_val1),
        .alu_val2       (alu_val2),
        .alu_imm        (alu_imm),
        .alu_pc         (alu_pc),
        .alu_rob_pos    (alu_rob_pos),
        .result         (result),
        .result_rob_pos (result_rob_pos),
        .result_val     (result_val),
        .result_jump    (result_jump),
        .result_pc      (result_pc)
`ifdef ALU_STATS_EN
        ,
        .stat_ops       (stat_ops),
        .stat_taken     (stat_taken)
`endif
    );

    task automatic chk(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    // Reference semantics computed with 64-bit integer arithmetic, truncated to 32 bits.
    task automatic ref_exec(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                            input logic [31:0] v1, input logic [31:0] v2,
                            input logic [31:0] imm, input logic [31:0] pc,
                            output logic [31:0] val, output logic jmp, output logic [31:0] npc);
        logic [31:0] b;
        longint s1, s2, u1, u2;
        int unsigned sh;
        logic take;
        val = 32'd0;
        jmp = 1'b0;
        npc = 32'(longint'(pc) + 64'd4);
        b   = (opc == OP) ? v2 : imm;
        if (opc == OP || opc == OPIMM) begin
            s1 = longint'($signed(v1));
            s2 = longint'($signed(b));
            u1 = longint'(v1);
            u2 = longint'(b);
            sh = 32'(u2 % 64'd32);
            case (f3)
                3'd0: val = (opc == OP && f7) ? 32'(u1 - u2) : 32'(u1 + u2);
                3'd1: val = 32'(u1 << sh);
                3'd2: val = (s1 < s2) ? 32'd1 : 32'd0;
                3'd3: val = (u1 < u2) ? 32'd1 : 32'd0;
                3'd4: val = v1 ^ b;
                3'd5: val = f7 ? 32'(s1 >>> sh) : 32'(u1 >> sh);
                3'd6: val = v1 | b;
                default: val = v1 & b;
            endcase
        end else if (opc == LUI) begin
            val = imm;
        end else if (opc == AUIPC) begin
            val = 32'(longint'(pc) + longint'(imm));
        end else if (opc == JAL || opc == JALR) begin
            val = npc;
            jmp = 1'b1;
            if (opc == JAL) npc = 32'(longint'(pc) + longint'(imm));
            else            npc = 32'((longint'(v1) + longint'(imm)) / 2 * 2);
        end else if (opc == BRANCH) begin
            s1 = longint'($signed(v1));
            s2 = longint'($signed(v2));
            u1 = longint'(v1);
            u2 = longint'(v2);
            case (f3)
                3'd0: take = (u1 == u2);
                3'd1: take = (u1 != u2);
                3'd4: take = (s1 < s2);
                3'd5: take = (s1 >= s2);
                3'd6: take = (u1 < u2);
                3'd7: take = (u1 >= u2);
                default: take = 1'b0;
            endcase
            if (take) begin
                jmp = 1'b1;
                npc = 32'(longint'(pc) + longint'(imm));
            end
        end
    endtask

    // Advance the model by one clock using the current inputs, then check every output.
    task automatic tick(input string tag);
        logic [31:0] v, p;
        logic j;
        ref_exec(alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2, alu_imm, alu_pc, v, j, p);
        if (rst) begin
            m_result = 1'b0; m_rob = 4'd0; m_val = 32'd0; m_jump = 1'b0; m_pc = 32'd0;
            m_ops = 32'd0; m_taken = 32'd0;
        end else if (rollback) begin
            m_result = 1'b0;
        end else if (rdy) begin
            m_result = alu_en;
            if (alu_en) begin
                m_rob = alu_rob_pos; m_val = v; m_jump = j; m_pc = p;
                m_ops = m_ops + 32'd1;
                if (j) m_taken = m_taken + 32'd1;
            end
        end
        @(posedge clk);
        #1;
        chk(tag, "result", 32'(result), 32'(m_result));
        chk(tag, "rob_pos", 32'(result_rob_pos), 32'(m_rob));
        chk(tag, "val", result_val, m_val);
        chk(tag, "jump", 32'(result_jump), 32'(m_jump));
        chk(tag, "pc", result_pc, m_pc);
`ifdef ALU_STATS_EN
        chk(tag, "stat_ops", stat_ops, m_ops);
        chk(tag, "stat_taken", stat_taken, m_taken);
`endif
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [3:0] rob);
        alu_en = 1'b1; alu_opcode = opc; alu_funct3 = f3; alu_funct7 = f7;
        alu_val1 = v1; alu_val2 = v2; alu_imm = imm; alu_pc = pc; alu_rob_pos = rob;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [6:0] opcs [8];
        opcs = '{OP, OPIMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD};

        rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
        drive(7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        alu_en = 1'b0;
        tick("reset");
        rst = 1'b0;
        tick("idle");
        chk("idle", "val_zero", result_val, 32'd0);
        chk("idle", "pc_zero", result_pc, 32'd0);

        drive(OP, 3'b000, 1'b1, 32'd5, 32'd7, 32'd0, 32'h200, 4'd3);
        tick("sub");
        chk("sub", "val_const", result_val, 32'hFFFF_FFFE);
        chk("sub", "rob_const", 32'(result_rob_pos), 32'd3);
        chk("sub", "pc_const", result_pc, 32'h204);
        alu_en = 1'b0;
        tick("sub_idle");
        chk("sub_idle", "result_const", 32'(result), 32'd0);

        drive(OPIMM, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 32'h300, 4'd5);
        tick("srai");
        chk("srai", "val_const", result_val, 32'hF800_0000);
        alu_funct7 = 1'b0;
        tick("srli");
        chk("srli", "val_const", result_val, 32'h0800_0000);

        drive(BRANCH, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd6);
        tick("blt");
        chk("blt", "pc_const", result_pc, 32'h120);
        alu_funct3 = 3'b110;
        tick("bltu");
        chk("bltu", "pc_const", result_pc, 32'h104);
        chk("bltu", "jump_const", 32'(result_jump), 32'd0);

        drive(JALR, 3'b000, 1'b0, 32'h1003, 32'd0, 32'd2, 32'h40, 4'd7);
        tick("jalr");
        chk("jalr", "val_const", result_val, 32'h44);
        chk("jalr", "pc_const", result_pc, 32'h1004);

        drive(LUI, 3'b000, 1'b0, 32'd0, 32'd0, 32'h1234_5000, 32'h80, 4'd9);
        rollback = 1'b1;
        tick("rollback");
        chk("rollback", "result_const", 32'(result), 32'd0);
        rollback = 1'b0;

        drive(JAL, 3'b000, 1'b0, 32'd0, 32'd0, 32'h10, 32'h500, 4'd2);
        tick("jal");
        drive(AUIPC, 3'b000, 1'b0, 32'd0, 32'd0, 32'h1000, 32'h600, 4'd4);
        rdy = 1'b0;
        tick("frozen");
        chk("frozen", "val_held", result_val, 32'h504);
        chk("frozen", "result_held", 32'(result), 32'd1);
        rdy = 1'b1;
        tick("auipc");
        drive(LOAD, 3'b010, 1'b0, 32'd8, 32'd0, 32'd4, 32'h700, 4'd11);
        tick("other_opcode");

        for (int i = 0; i < 600; i++) begin
            drive(opcs[$urandom_range(0, 7)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  pick(), pick(), pick(), pick(), 4'($urandom_range(0, 15)));
            alu_en   = ($urandom_range(0, 3) != 0);
            rdy      = ($urandom_range(0, 7) != 0);
            rollback = ($urandom_range(0, 15) == 0);
            rst      = ($urandom_range(0, 99) == 0);
            tick("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Single-issue integer execute stage directly downstream of the reservation station.
- Accepts at most one ready RV32I op per cycle (alu_en plus operands) and computes its result, branch outcome and next PC.
- Registers the result and broadcasts it one cycle later on the ALU result bus.
- That bus feeds the ROB, the reservation station wake-up logic and the load/store buffer.
- No backpressure: an op is accepted every cycle alu_en is high.

Parameters:
- None. Widths come from the shared macros: OPCODE_WID 6:0, FUNCT3_WID 2:0, DATA_WID 31:0, ADDR_WID 31:0, ROB_POS_WID 3:0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; low = freeze all state
- rollback  in  1  misprediction flush
- alu_en  in  1  op valid this cycle
- alu_opcode  in  7  instruction opcode
- alu_funct3  in  3  funct3
- alu_funct7  in  1  instruction bit 30
- alu_val1  in  32  rs1 value
- alu_val2  in  32  rs2 value
- alu_imm  in  32  sign-extended immediate, already decoded
- alu_pc  in  32  instruction PC
- alu_rob_pos  in  4  destination ROB slot
- result  out  1  broadcast valid
- result_rob_pos  out  4  ROB slot of result
- result_val  out  32  rd write value
- result_jump  out  1  control transfer taken
- result_pc  out  32  actual next PC

Behaviour:
- Clock, reset and enables:
  - Clock is clk. Reset is synchronous and active-high on rst. All state updates occur on posedge clk.
  - Priority: rst or rollback > !rdy > normal.
  - rst: all outputs become 0.
  - rollback: result becomes 0; other outputs keep their values (don't-care). An op presented with alu_en in the same cycle as rollback is dropped.
  - !rdy: every register holds, including result. An alu_en op in that cycle is dropped; the upstream stage is frozen by the same rdy.
- Normal cycle:
  - result <= alu_en. When alu_en is high, all other outputs are loaded; otherwise they hold.
  - Latency is exactly 1 cycle. Throughput is 1 op per cycle. Back-to-back ops produce back-to-back broadcasts.
- Operand selection:
  - OP (0110011): second operand = val2.
  - OP-IMM (0010011): second operand = imm.
  - Shift amount is the low 5 bits of the second operand.
- Arithmetic by funct3:
  - 000: ADD. SUB only when OP and funct7=1.
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when funct7=1 (both OP and OP-IMM).
  - 110: OR.
  - 111: AND.
  - For OP/OP-IMM: result_jump=0, result_pc=pc+4.
- LUI (0110111): val=imm, jump=0, pc=pc+4.
- AUIPC (0010111): val=pc+imm, jump=0, pc=pc+4.
- JAL (1101111): val=pc+4, jump=1, pc=pc+imm.
- JALR (1100111): val=pc+4, jump=1, pc=(val1+imm)&~1.
- BRANCH (1100011):
  - Condition by funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU. Signed compares for BLT/BGE.
  - val=0.
  - Taken: jump=1, pc=pc+imm. Not taken: jump=0, pc=pc+4.
  - funct3 010/011 are treated as not taken.
- Any other opcode: val=0, jump=0, pc=pc+4. Result is still broadcast so the ROB entry completes.
- Arithmetic rules: all arithmetic is 32-bit and wraps modulo 2^32. No exceptions are raised. result_rob_pos is a straight copy of alu_rob_pos.

Optional Feature:
- Macro ALU_STATS_EN. When defined, the block adds three things:
  - Output stat_ops (32 bits): counts ops that were accepted (result written 1).
  - Output stat_taken (32 bits): counts accepted ops with result_jump=1.
  - Both counters clear on rst only, survive rollback, hold when !rdy, and wrap at 2^32.
- When not defined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- rst high for 1 cycle, then idle -> result=0, result_val=0, result_pc=0, result_jump=0.
- OP, funct3=000, funct7=1, val1=5, val2=7, rob_pos=3 -> next cycle: result=1, rob_pos=3, val=0xFFFFFFFE, jump=0, pc=pc+4. Following cycle with alu_en=0 -> result=0.
- OP-IMM SRAI (funct3=101, funct7=1), val1=0x80000000, imm=4 -> val=0xF8000000. Same with funct7=0 -> val=0x08000000.
- BLT with val1=-1, val2=1, pc=0x100, imm=0x20 -> jump=1, pc=0x120. BLTU with the same operands -> jump=0, pc=0x104.
- JALR with val1=0x1003, imm=2, pc=0x40 -> val=0x44, pc=0x1004, jump=1.
- alu_en together with rollback -> no broadcast next cycle. alu_en while rdy=0 -> outputs unchanged, op dropped.
